z80_uart_tx: RTL and testbench
==============================

// Module: z80_uart_tx
// PURPOSE
//   Bus-side UART transmitter for the Z80 system. Decodes CPU I/O writes to DATA_PORT
//   (the console character port, 0xBB) and queues each byte in a small FIFO.
//   Each queued byte is serialised onto s_tx as 8N1.
//   Also exposes a read-only status register at STATUS_PORT, which the top level muxes onto dbus_in.
// PARAMETERS
//   CLKS_PER_BIT  434    clk cycles per serial bit (50 MHz / 115200); must be >= 2
//   FIFO_DEPTH    8      TX FIFO entries; power of two, >= 2
//   DATA_PORT     8'hBB  I/O address; a write pushes a byte to the FIFO
//   STATUS_PORT   8'hBC  I/O address; a read returns the status byte
// PORTS
//   clk         in   1  system clock; single clock domain
//   reset_n     in   1  asynchronous, active-low reset
//   address     in   8  CPU address bus A[7:0]
//   io_din      in   8  CPU data out (dbus_out)
//   iorq_n      in   1  CPU I/O request, active low
//   wr_n        in   1  CPU write strobe, active low
//   rd_n        in   1  CPU read strobe, active low
//   io_dout     out  8  status byte toward dbus_in mux
//   io_rd_sel   out  1  1 = drive io_dout onto dbus_in this cycle
//   s_tx        out  1  serial transmit line, idle high
// BEHAVIOUR
//   Reset (async assert, sync release): s_tx=1, FIFO empty, FSM=IDLE, overflow=0, strobe regs=0.
//   Reset mid-frame aborts the frame. s_tx goes to 1 without waiting for a clock; queued data is lost.
//   Write strobe
//     wr_stb = !iorq_n & !wr_n & (address==DATA_PORT), registered into wr_stb_d each clk.
//     Push occurs on the clk edge where wr_stb=1 and wr_stb_d=0; io_din is captured at that edge.
//     Exactly one push per CPU OUT, regardless of how many cycles the strobe stays low.
//   FIFO full
//     Full when count==FIFO_DEPTH, using the count before this edge.
//     A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
//     Pointers wrap modulo FIFO_DEPTH; count is tracked with log2(FIFO_DEPTH)+1 bits.
//   Read path (combinational)
//     io_rd_sel = !iorq_n & !rd_n & (address==STATUS_PORT).
//     io_dout = {4'b0, busy, overflow, full, tx_empty}.
//     tx_empty = FIFO empty & FSM==IDLE; busy = FSM!=IDLE.
//     io_dout is valid whenever io_rd_sel=1; it is 8'h00 otherwise.
//   Overflow clear
//     overflow clears on the edge where io_rd_sel_d=1 and io_rd_sel=0 (end of the status read).
//     The read itself therefore still returns overflow=1.
//     If set and clear occur on the same edge, set wins.
//   Serialiser FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//     IDLE: if FIFO non-empty, pop into shift reg, bit_cnt=0, baud_cnt=0, go START.
//     START: s_tx=0 for CLKS_PER_BIT clks.
//     DATA: s_tx=shift[0], LSB first; shift right every CLKS_PER_BIT clks.
//       After 8 bits go STOP.
//     STOP: s_tx=1 for CLKS_PER_BIT clks, then IDLE.
//     s_tx is registered and glitch-free.
//   Latency and frame timing
//     Push at edge N -> pop at edge N+1 -> s_tx falls at edge N+2.
//     One frame = 10*CLKS_PER_BIT clks.
//     Back-to-back frames have exactly 1 idle clk between the stop bit and the next start bit.
//   Accesses to any other port, or memory cycles (iorq_n=1), have no effect on state.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=8)
//   1 Reset: release reset_n, read 0xBC -> io_rd_sel=1, io_dout=8'h01, s_tx=1.
//   2 Single byte: OUT 0xBB,0x55 with strobe held low 3 clks.
//     Expect exactly one frame: 0,1,0,1,0,1,0,1,0,1, each bit 4 clks (40 clks total).
//     s_tx falls 2 clks after the push edge. Status afterwards = 8'h01.
//   3 Overflow: 10 back-to-back OUTs of 0x00..0x09.
//     Expect frames for 0x00..0x08 in order; 0x09 is dropped.
//     Status reads 8'h0E while the FIFO is full with overflow set and FSM busy.
//   4 Overflow clear: read 0xBC with overflow=1.
//     The read returns bit2=1; the next read returns bit2=0.
//     A dropped push on the same edge as the clear leaves overflow=1.
//   5 Reset mid-frame: assert reset_n during DATA bit 3.
//     Expect s_tx=1 asynchronously, status 8'h01 after release, and no residual frame.
//   6 Decode: OUT to 0xBA and IN from 0xBB.
//     Expect no push, io_rd_sel=0, io_dout=8'h00, s_tx stays 1.

Source files
------------

// File: rtl/z80_uart_tx.sv
// z80_uart_tx: Z80 I/O-mapped UART transmitter.
//   A CPU OUT to DATA_PORT queues one byte in a TX FIFO. Each queued byte is
//   sent on s_tx as 8N1, LSB first. A CPU IN from STATUS_PORT returns
//   {4'b0, busy, overflow, full, tx_empty} on io_dout while io_rd_sel is high.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   address, io_din       CPU address A[7:0] and CPU data out
//   iorq_n, wr_n, rd_n    CPU I/O request, write and read strobes (active low)
//   io_dout, io_rd_sel    status byte and its dbus_in select (combinational)
//   s_tx                  serial transmit line, registered, idle high
module z80_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter logic [7:0]  DATA_PORT    = 8'hBB,
    parameter logic [7:0]  STATUS_PORT  = 8'hBC
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] address,
    input  logic [7:0] io_din,
    input  logic       iorq_n,
    input  logic       wr_n,
    input  logic       rd_n,
    output logic [7:0] io_dout,
    output logic       io_rd_sel,
    output logic       s_tx
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_n;
    logic [7:0]        shift, shift_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic              tx_n;
    logic              pop;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              wr_stb, wr_stb_d, rd_sel_d;
    logic              push, push_ok, full, rd_clr;

    // Bus decode and strobe edge detection
    assign wr_stb    = !iorq_n && !wr_n && (address == DATA_PORT);
    assign io_rd_sel = !iorq_n && !rd_n && (address == STATUS_PORT);
    assign push      = wr_stb && !wr_stb_d;
    assign rd_clr    = rd_sel_d && !io_rd_sel;
    assign full      = (count == CNT_FULL);
    assign push_ok   = push && !full;

    // Status byte, forced to zero when not selected
    assign io_dout = io_rd_sel
                   ? {4'b0000, (state != IDLE), overflow, full,
                      ((count == '0) && (state == IDLE))}
                   : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_stb_d <= 1'b0;
            rd_sel_d <= 1'b0;
        end else begin
            wr_stb_d <= wr_stb;
            rd_sel_d <= io_rd_sel;
        end
    end

    // FIFO pointers, occupancy and sticky overflow (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && full)  overflow <= 1'b1;
            else if (rd_clr)   overflow <= 1'b0;
        end
    end

    // FIFO storage; contents need no reset
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= io_din;
    end

    // Serialiser state register; s_tx lags the state by one clock
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
            s_tx     <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            baud_cnt <= baud_cnt_n;
            s_tx     <= tx_n;
        end
    end

    // Serialiser next-state and line value
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        baud_cnt_n = baud_cnt;
        pop        = 1'b0;
        tx_n       = 1'b1;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    shift_n    = mem[rd_ptr];
                    bit_cnt_n  = 3'd0;
                    baud_cnt_n = '0;
                    state_n    = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + BAUD_W'(1);
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    if (bit_cnt == 3'd7) state_n   = STOP;
                    else                 bit_cnt_n = bit_cnt + 3'd1;
                end else begin
                    baud_cnt_n = baud_cnt + BAUD_W'(1);
                end
            end
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_z80_uart_tx.sv
// tb_z80_uart_tx: directed bench for z80_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=8.
//   A vector table covers reset status and port decode; hand-written sequences
//   cover frame timing, FIFO overflow/clear and reset mid-frame. A line
//   monitor decodes frames on s_tx into rx_q as {stop_bit, byte}.
module tb_z80_uart_tx;

    localparam int unsigned CPB = 4;

    logic       clk;
    logic       reset_n;
    logic [7:0] address;
    logic [7:0] io_din;
    logic       iorq_n;
    logic       wr_n;
    logic       rd_n;
    logic [7:0] io_dout;
    logic       io_rd_sel;
    logic       s_tx;

    int n_vec = 0;
    int n_err = 0;

    logic [8:0] rx_q[$];

    z80_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (8),
        .DATA_PORT   (8'hBB),
        .STATUS_PORT (8'hBC)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .address  (address),
        .io_din   (io_din),
        .iorq_n   (iorq_n),
        .wr_n     (wr_n),
        .rd_n     (rd_n),
        .io_dout  (io_dout),
        .io_rd_sel(io_rd_sel),
        .s_tx     (s_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       iorq_n;
        logic       rd_n;
        logic       wr_n;
        logic [7:0] addr;
        logic [7:0] din;
        logic       exp_sel;
        logic [7:0] exp_dout;
        logic       exp_tx;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Drive the bus just after a rising edge
    task automatic set_bus(input logic iq, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        iorq_n  = iq;
        rd_n    = rd;
        wr_n    = wr;
        address = a;
        io_din  = d;
    endtask

    task automatic bus_idle();
        set_bus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
    endtask

    // Full IN cycle from the status port, checked mid-cycle, then bus released
    task automatic read_status(input string name, input logic [7:0] exp);
        set_bus(1'b0, 1'b0, 1'b1, 8'hBC, 8'h00);
        @(negedge clk);
        chk(name, {io_rd_sel, io_dout}, {1'b1, exp});
        bus_idle();
    endtask

    // Frame decoder: samples each bit one clock into its bit period
    initial begin : monitor
        logic [7:0] b;
        logic       stp;
        b = '0;
        forever begin
            @(negedge clk);
            if (reset_n && s_tx === 1'b0) begin
                @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = s_tx;
                end
                repeat (CPB) @(negedge clk);
                stp = s_tx;
                rx_q.push_back({stp, b});
            end
        end
    end

    initial begin : main
        logic [43:0] got_w, exp_w;
        logic [9:0]  frame;
        logic        all_high;
        int          waited;

        reset_n = 1'b0;
        iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; address = 8'h00; io_din = 8'h00;

        vecs[0] = '{"idle",       1, 1, 1, 8'h00, 8'h00, 0, 8'h00, 1};
        vecs[1] = '{"rd_status",  0, 0, 1, 8'hBC, 8'h00, 1, 8'h01, 1};
        vecs[2] = '{"out_ba",     0, 1, 0, 8'hBA, 8'h41, 0, 8'h00, 1};
        vecs[3] = '{"idle2",      1, 1, 1, 8'h00, 8'h00, 0, 8'h00, 1};
        vecs[4] = '{"in_bb",      0, 0, 1, 8'hBB, 8'h00, 0, 8'h00, 1};
        vecs[5] = '{"mem_wr_bb",  1, 1, 0, 8'hBB, 8'h77, 0, 8'h00, 1};
        vecs[6] = '{"mem_rd_bc",  1, 0, 1, 8'hBC, 8'h00, 0, 8'h00, 1};
        vecs[7] = '{"out_bc",     0, 1, 0, 8'hBC, 8'h33, 0, 8'h00, 1};
        vecs[8] = '{"rd_status2", 0, 0, 1, 8'hBC, 8'h00, 1, 8'h01, 1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_s_tx", 64'(s_tx), 64'(1'b1));
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset status and port decode table
        foreach (vecs[i]) begin
            set_bus(vecs[i].iorq_n, vecs[i].rd_n, vecs[i].wr_n, vecs[i].addr, vecs[i].din);
            @(negedge clk);
            chk(vecs[i].name, 64'({io_rd_sel, io_dout, s_tx}),
                64'({vecs[i].exp_sel, vecs[i].exp_dout, vecs[i].exp_tx}));
        end
        bus_idle();
        all_high = 1'b1;
        repeat (20) begin
            @(negedge clk);
            all_high &= s_tx;
        end
        chk("decode_line_idle", 64'(all_high), 64'(1'b1));
        chk("decode_no_frame", 64'(rx_q.size()), 64'(0));

        // Single byte, strobe held for 3 clocks
        set_bus(1'b0, 1'b1, 1'b0, 8'hBB, 8'h55);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                iorq_n = 1'b1; wr_n = 1'b1; address = 8'h00; io_din = 8'h00;
            end
            begin
                @(posedge clk);
                for (int i = 0; i < 44; i++) begin
                    @(negedge clk);
                    got_w[i] = s_tx;
                end
            end
        join
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 44; i++)
            exp_w[i] = (i < 2 || i >= 42) ? 1'b1 : frame[(i - 2) / 4];
        chk("frame_55_wave", 64'(got_w), 64'(exp_w));
        repeat (10) @(posedge clk);
        read_status("status_after_55", 8'h01);
        chk("rx_count_55", 64'(rx_q.size()), 64'(1));
        chk("rx_byte_55", 64'(rx_q.size() > 0 ? rx_q[0] : 9'h000), 64'({1'b1, 8'h55}));
        rx_q.delete();

        // Ten back-to-back OUTs; the tenth finds the FIFO full
        for (int k = 0; k < 10; k++) begin
            set_bus(1'b0, 1'b1, 1'b0, 8'hBB, 8'(k));
            bus_idle();
        end
        set_bus(1'b0, 1'b0, 1'b1, 8'hBC, 8'h00);
        @(negedge clk);
        chk("status_full_ovf", 64'({io_rd_sel, io_dout}), 64'({1'b1, 8'h0E}));
        // Dropped push on the same edge the read ends: overflow must stay set
        set_bus(1'b0, 1'b1, 1'b0, 8'hBB, 8'h0A);
        @(negedge clk);
        chk("out_during_clear_sel", 64'({io_rd_sel, io_dout}), 64'({1'b0, 8'h00}));
        read_status("status_set_wins", 8'h0E);
        read_status("status_ovf_cleared", 8'h0A);

        waited = 0;
        while (rx_q.size() < 9 && waited < 800) begin
            @(posedge clk);
            waited++;
        end
        repeat (60) @(posedge clk);
        chk("ovf_frame_count", 64'(rx_q.size()), 64'(9));
        for (int k = 0; k < 9; k++)
            chk($sformatf("ovf_frame_%0d", k),
                64'(k < rx_q.size() ? rx_q[k] : 9'h1FF), 64'({1'b1, 8'(k)}));
        read_status("status_after_ovf", 8'h01);
        rx_q.delete();

        // Reset during data bit 3 of 0xA5 (bit 3 = 0)
        set_bus(1'b0, 1'b1, 1'b0, 8'hBB, 8'hA5);
        bus_idle();
        repeat (19) @(posedge clk);
        #2;
        chk("pre_reset_bit3", 64'(s_tx), 64'(1'b0));
        reset_n = 1'b0;
        #1;
        chk("async_reset_s_tx", 64'(s_tx), 64'(1'b1));
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        read_status("status_after_abort", 8'h01);
        all_high = 1'b1;
        repeat (100) begin
            @(negedge clk);
            all_high &= s_tx;
        end
        chk("no_residual_frame", 64'(all_high), 64'(1'b1));
        read_status("status_final", 8'h01);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
